// File: rtl/dino_kbd_pkg.sv
// Scan-code constants, prefix FSM encoding and held-key bit positions shared by the key mapper.
package dino_kbd_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_OVR0  = 8'h00;
  localparam logic [7:0] SC_OVRF  = 8'hFF;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GOT_E0   = 2'd1;
  localparam logic [1:0] ST_GOT_F0   = 2'd2;
  localparam logic [1:0] ST_GOT_E0F0 = 2'd3;

  // keys_held bit order is {ENTER, DOWN, UP, SPACE}; ESC lives above it when pause is built in
  localparam int KEY_SPACE = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_ENTER = 3;
  localparam int KEY_ESC   = 4;

  function automatic logic is_overrun(input logic [7:0] b);
    return (b == SC_OVR0) || (b == SC_OVRF);
  endfunction

endpackage

// File: rtl/dino_key_edge.sv
// One held flag per game key: make sets, break clears, clr wins; rise pulses one cycle on a fresh make.
// Latency 1 cycle; no backpressure (strobes are consumed the cycle they arrive).
module dino_key_edge
  import dino_kbd_pkg::*;
(
  input  logic clk,
  input  logic resetN,
  input  logic i_make,
  input  logic i_brk,
  input  logic i_clr,
  output logic o_held,
  output logic o_rise
);

  logic r_held;
  logic r_rise;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_held <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      // typematic repeats arrive as makes while already held and must not pulse
      r_rise <= i_make & ~r_held & ~i_clr;
      if (i_clr)
        r_held <= 1'b0;
      else if (i_make)
        r_held <= 1'b1;
      else if (i_brk)
        r_held <= 1'b0;
    end
  end

  assign o_held = r_held;
  assign o_rise = r_rise;

endmodule

// File: rtl/dino_key_mapper.sv
// PS/2 scan bytes -> game controls: E0/F0 prefix FSM with timeout, held flags, one pulse per press.
// Latency 1 cycle after byte_valid; no backpressure, every strobe is consumed (frame_err drops the byte).
// DINO_ESC_PAUSE_EN: ESC makes toggle pause; otherwise pause is tied low.
module dino_key_mapper
  import dino_kbd_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 50000,
  parameter int TIMER_W        = 16
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       frame_err,
  output logic       jump_pulse,
  output logic       duck,
  output logic       start_pulse,
  output logic [3:0] keys_held,
  output logic       pause
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PREFIX_TIMEOUT - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic               w_is_e0;
  logic               w_is_f0;
  logic               w_clr;
  logic               w_make;
  logic               w_brk;
  logic               w_ext;
  logic               w_sc_space;
  logic               w_sc_up;
  logic               w_sc_down;
  logic               w_sc_enter;
  logic [3:0]         w_held;
  logic               w_rise_space;
  logic               w_rise_up;
  logic               w_rise_down;
  logic               w_rise_enter;

  assign w_is_e0 = (byte_data == SC_E0);
  assign w_is_f0 = (byte_data == SC_F0);
  assign w_clr   = byte_valid & ~frame_err & is_overrun(byte_data);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    if (frame_err) begin
      w_state_nxt = ST_IDLE;
      w_timer_nxt = '0;
    end else if (byte_valid) begin
      w_timer_nxt = '0;
      if (is_overrun(byte_data)) begin
        w_state_nxt = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_is_e0)
              w_state_nxt = ST_GOT_E0;
            else if (w_is_f0)
              w_state_nxt = ST_GOT_F0;
            else
              w_make = 1'b1;
          end
          ST_GOT_E0: begin
            if (w_is_f0) begin
              w_state_nxt = ST_GOT_E0F0;
            end else if (!w_is_e0) begin
              w_state_nxt = ST_IDLE;
              w_make      = 1'b1;
              w_ext       = 1'b1;
            end
          end
          ST_GOT_F0: begin
            // a prefix after F0 is a protocol error: drop back without touching keys
            w_state_nxt = ST_IDLE;
            w_brk       = ~(w_is_e0 | w_is_f0);
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_brk       = ~(w_is_e0 | w_is_f0);
            w_ext       = 1'b1;
          end
        endcase
      end
    end else if (r_state != ST_IDLE) begin
      if (r_timer == TIMER_LAST) begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end else begin
        w_timer_nxt = r_timer + TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  assign w_sc_space = ~w_ext & (byte_data == SC_SPACE);
  assign w_sc_up    =  w_ext & (byte_data == SC_UP);
  assign w_sc_down  =  w_ext & (byte_data == SC_DOWN);
  assign w_sc_enter = ~w_ext & (byte_data == SC_ENTER);

  dino_key_edge u_space (
    .clk(clk), .resetN(resetN),
    .i_make(w_make & w_sc_space), .i_brk(w_brk & w_sc_space), .i_clr(w_clr),
    .o_held(w_held[KEY_SPACE]), .o_rise(w_rise_space)
  );

  dino_key_edge u_up (
    .clk(clk), .resetN(resetN),
    .i_make(w_make & w_sc_up), .i_brk(w_brk & w_sc_up), .i_clr(w_clr),
    .o_held(w_held[KEY_UP]), .o_rise(w_rise_up)
  );

  dino_key_edge u_down (
    .clk(clk), .resetN(resetN),
    .i_make(w_make & w_sc_down), .i_brk(w_brk & w_sc_down), .i_clr(w_clr),
    .o_held(w_held[KEY_DOWN]), .o_rise(w_rise_down)
  );

  dino_key_edge u_enter (
    .clk(clk), .resetN(resetN),
    .i_make(w_make & w_sc_enter), .i_brk(w_brk & w_sc_enter), .i_clr(w_clr),
    .o_held(w_held[KEY_ENTER]), .o_rise(w_rise_enter)
  );

  // only one key can be decoded per byte, so the two jump sources never overlap
  assign jump_pulse  = w_rise_space | w_rise_up;
  assign start_pulse = w_rise_enter;
  assign duck        = w_held[KEY_DOWN];
  assign keys_held   = w_held;

  logic w_unused_down_rise;
  assign w_unused_down_rise = w_rise_down;

`ifdef DINO_ESC_PAUSE_EN
  logic w_sc_esc;
  logic w_held_esc;
  logic w_rise_esc;
  logic r_pause;

  assign w_sc_esc = ~w_ext & (byte_data == SC_ESC);

  dino_key_edge u_esc (
    .clk(clk), .resetN(resetN),
    .i_make(w_make & w_sc_esc), .i_brk(w_brk & w_sc_esc), .i_clr(w_clr),
    .o_held(w_held_esc), .o_rise(w_rise_esc)
  );

  // r_pause lags by the rise pulse; folding the pulse back in gives pause the same 1-cycle latency
  always_ff @(posedge clk) begin
    if (!resetN)
      r_pause <= 1'b0;
    else
      r_pause <= r_pause ^ w_rise_esc;
  end

  assign pause = r_pause ^ w_rise_esc;

  logic w_unused_esc_held;
  assign w_unused_esc_held = w_held_esc;
`else
  assign pause = 1'b0;
`endif

endmodule

// File: tb/tb_dino_key_mapper.sv
// Directed scenarios with constant expectations, then random bytes checked against a prefix-flag model.
module tb_dino_key_mapper;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       frame_err = 1'b0;
  logic       jump_pulse, duck, start_pulse, pause;
  logic [3:0] keys_held;

  always #5 clk = ~clk;

  dino_key_mapper #(.PREFIX_TIMEOUT(TO), .TIMER_W(8)) dut (
    .clk(clk), .resetN(resetN), .byte_valid(byte_valid), .byte_data(byte_data),
    .frame_err(frame_err), .jump_pulse(jump_pulse), .duck(duck), .start_pulse(start_pulse),
    .keys_held(keys_held), .pause(pause)
  );

  wire [7:0] obs = {jump_pulse, duck, start_pulse, keys_held, pause};

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: pending-prefix flags, age of the pending prefix, held set indexed by key id
  logic [4:0] m_held = '0;
  bit m_e0 = 0, m_f0 = 0, m_jump = 0, m_start = 0, m_pause = 0;
  int m_age = 0;

  function automatic int key_of(bit ext, logic [7:0] code);
    if (!ext && code == 8'h29) return 0;
    if ( ext && code == 8'h75) return 1;
    if ( ext && code == 8'h72) return 2;
    if (!ext && code == 8'h5A) return 3;
`ifdef DINO_ESC_PAUSE_EN
    if (!ext && code == 8'h76) return 4;
`endif
    return -1;
  endfunction

  task automatic model_step(bit rn, bit bv, logic [7:0] d, bit fe);
    int k;
    m_jump  = 0;
    m_start = 0;
    if (!rn) begin
      m_held = '0; m_e0 = 0; m_f0 = 0; m_age = 0; m_pause = 0;
    end else if (fe) begin
      m_e0 = 0; m_f0 = 0; m_age = 0;
    end else if (bv) begin
      m_age = 0;
      if (d == 8'h00 || d == 8'hFF) begin
        m_held = '0; m_e0 = 0; m_f0 = 0;
      end else if (d == 8'hE0 || d == 8'hF0) begin
        if (m_f0) begin
          m_e0 = 0; m_f0 = 0;
        end else if (d == 8'hE0) m_e0 = 1;
        else m_f0 = 1;
      end else begin
        k = key_of(m_e0, d);
        if (k >= 0) begin
          if (m_f0) m_held[k] = 1'b0;
          else if (!m_held[k]) begin
            m_held[k] = 1'b1;
            if (k == 0 || k == 1) m_jump = 1;
            if (k == 3) m_start = 1;
            if (k == 4) m_pause = !m_pause;
          end
        end
        m_e0 = 0; m_f0 = 0;
      end
    end else if (m_e0 || m_f0) begin
      if (m_age == TO - 1) begin
        m_e0 = 0; m_f0 = 0; m_age = 0;
      end else m_age++;
    end
  endtask

  function automatic logic [7:0] model_vec();
    return {m_jump, m_held[2], m_start, m_held[3:0], m_pause};
  endfunction

  function automatic logic [7:0] pack(bit j, bit dk, bit s, logic [3:0] k, bit p);
    return {j, dk, s, k, p};
  endfunction

  task automatic drive(bit rn, bit bv, logic [7:0] d, bit fe);
    resetN = rn; byte_valid = bv; byte_data = d; frame_err = fe;
    @(posedge clk);
    model_step(rn, bv, d, fe);
    #1;
  endtask

  task automatic send(logic [7:0] d);
    drive(1, 1, d, 0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1, 0, 8'h00, 0);
  endtask

  task automatic test_reset();
    drive(0, 0, 8'h00, 0);
    drive(0, 1, 8'h29, 0);
    n_checks++;
    if (obs !== 8'h00) begin n_fail++; $display("FAIL reset_state: got %b want %b", obs, 8'h00); end
    idle(1);
    n_checks++;
    if (obs !== 8'h00) begin n_fail++; $display("FAIL reset_release: got %b want %b", obs, 8'h00); end
  endtask

  task automatic test_space();
    send(8'h29);
    n_checks++;
    if (obs !== pack(1,0,0,4'b0001,0)) begin n_fail++; $display("FAIL space_make: got %b want %b", obs, pack(1,0,0,4'b0001,0)); end
    idle(1);
    n_checks++;
    if (obs !== pack(0,0,0,4'b0001,0)) begin n_fail++; $display("FAIL space_pulse_width: got %b want %b", obs, pack(0,0,0,4'b0001,0)); end
    for (int i = 0; i < 3; i++) begin
      send(8'h29);
      n_checks++;
      if (obs !== pack(0,0,0,4'b0001,0)) begin n_fail++; $display("FAIL space_repeat%0d: got %b want %b", i, obs, pack(0,0,0,4'b0001,0)); end
    end
    send(8'hF0); send(8'h29);
    n_checks++;
    if (obs !== 8'h00) begin n_fail++; $display("FAIL space_break: got %b want %b", obs, 8'h00); end
  endtask

  task automatic test_duck();
    send(8'hE0); send(8'h72);
    n_checks++;
    if (obs !== pack(0,1,0,4'b0100,0)) begin n_fail++; $display("FAIL duck_make: got %b want %b", obs, pack(0,1,0,4'b0100,0)); end
    send(8'hE0); send(8'hF0); send(8'h72);
    n_checks++;
    if (obs !== 8'h00) begin n_fail++; $display("FAIL duck_break: got %b want %b", obs, 8'h00); end
    send(8'h72);
    n_checks++;
    if (obs !== 8'h00) begin n_fail++; $display("FAIL keypad2_no_duck: got %b want %b", obs, 8'h00); end
  endtask

  task automatic test_timeout();
    send(8'hE0); idle(TO - 1); send(8'h75);
    n_checks++;
    if (obs !== pack(1,0,0,4'b0010,0)) begin n_fail++; $display("FAIL timeout_edge_still_pending: got %b want %b", obs, pack(1,0,0,4'b0010,0)); end
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); idle(TO); send(8'h75);
    n_checks++;
    if (obs !== 8'h00) begin n_fail++; $display("FAIL timeout_expired: got %b want %b", obs, 8'h00); end
  endtask

  task automatic test_overrun();
    send(8'h29); send(8'hE0); send(8'h72);
    n_checks++;
    if (obs !== pack(0,1,0,4'b0101,0)) begin n_fail++; $display("FAIL hold_two: got %b want %b", obs, pack(0,1,0,4'b0101,0)); end
    send(8'hFF);
    n_checks++;
    if (obs !== 8'h00) begin n_fail++; $display("FAIL overrun_ff: got %b want %b", obs, 8'h00); end
    send(8'hF0); send(8'hE0);
    n_checks++;
    if (obs !== 8'h00) begin n_fail++; $display("FAIL proto_err: got %b want %b", obs, 8'h00); end
    // the error returns to IDLE, so the trailing 29 is an ordinary SPACE make
    send(8'h29);
    n_checks++;
    if (obs !== pack(1,0,0,4'b0001,0)) begin n_fail++; $display("FAIL after_err_make: got %b want %b", obs, pack(1,0,0,4'b0001,0)); end
    send(8'hE0); send(8'h00); send(8'h72);
    n_checks++;
    if (obs !== 8'h00) begin n_fail++; $display("FAIL overrun_00_in_prefix: got %b want %b", obs, 8'h00); end
  endtask

  task automatic test_frame_err();
    drive(1, 1, 8'h29, 1);
    n_checks++;
    if (obs !== 8'h00) begin n_fail++; $display("FAIL fe_drops_byte: got %b want %b", obs, 8'h00); end
    send(8'h29);
    drive(1, 1, 8'hE0, 1);
    n_checks++;
    if (obs !== pack(0,0,0,4'b0001,0)) begin n_fail++; $display("FAIL fe_keys_kept: got %b want %b", obs, pack(0,0,0,4'b0001,0)); end
    send(8'h75);
    n_checks++;
    if (obs !== pack(0,0,0,4'b0001,0)) begin n_fail++; $display("FAIL fe_drops_e0: got %b want %b", obs, pack(0,0,0,4'b0001,0)); end
    send(8'hE0); drive(1, 0, 8'h00, 1); send(8'h72);
    n_checks++;
    if (obs !== pack(0,0,0,4'b0001,0)) begin n_fail++; $display("FAIL fe_alone_clears_prefix: got %b want %b", obs, pack(0,0,0,4'b0001,0)); end
    send(8'hF0); drive(0, 0, 8'h00, 0); send(8'h5A);
    n_checks++;
    if (obs !== pack(0,0,1,4'b1000,0)) begin n_fail++; $display("FAIL reset_mid_seq: got %b want %b", obs, pack(0,0,1,4'b1000,0)); end
    send(8'hF0); send(8'h5A);
  endtask

  task automatic test_back_to_back();
    send(8'h29);
    n_checks++;
    if (obs !== pack(1,0,0,4'b0001,0)) begin n_fail++; $display("FAIL b2b_space: got %b want %b", obs, pack(1,0,0,4'b0001,0)); end
    send(8'h5A);
    n_checks++;
    if (obs !== pack(0,0,1,4'b1001,0)) begin n_fail++; $display("FAIL b2b_enter: got %b want %b", obs, pack(0,0,1,4'b1001,0)); end
    send(8'hE0);
    send(8'h75);
    n_checks++;
    if (obs !== pack(1,0,0,4'b1011,0)) begin n_fail++; $display("FAIL b2b_up: got %b want %b", obs, pack(1,0,0,4'b1011,0)); end
    send(8'hF0); send(8'h29); send(8'hF0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h75);
    n_checks++;
    if (obs !== 8'h00) begin n_fail++; $display("FAIL b2b_release_all: got %b want %b", obs, 8'h00); end
  endtask

  task automatic test_pause();
    logic [7:0] seq [4];
    logic       want [4];
    seq = '{8'h76, 8'h76, 8'h76, 8'h76};
`ifdef DINO_ESC_PAUSE_EN
    want = '{1'b1, 1'b1, 1'b1, 1'b0};
`else
    want = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      if (i == 2) send(8'hF0);
      send(seq[i]);
      n_checks++;
      if (obs !== pack(0,0,0,4'b0000,want[i])) begin n_fail++; $display("FAIL pause_step%0d: got %b want %b", i, obs, pack(0,0,0,4'b0000,want[i])); end
    end
  endtask

  task automatic test_random();
    logic [7:0] tbl [12];
    int r, n;
    bit rn, bv, fe;
    logic [7:0] d;
    tbl = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h29, 8'h75, 8'h72, 8'h5A, 8'h76, 8'h00, 8'hFF, 8'h12};
    drive(0, 0, 8'h00, 0);
    for (int it = 0; it < 3000; it++) begin
      r = $urandom_range(0, 99);
      n = 1; rn = 1; bv = 0; fe = 0; d = 8'($urandom);
      if (r < 60) begin
        bv = 1; d = tbl[$urandom_range(0, 11)];
        if (d == 8'h12) d = 8'($urandom);
      end else if (r < 65) begin
        fe = 1; bv = 1'($urandom); d = tbl[$urandom_range(0, 11)];
      end else if (r < 68) begin
        n = $urandom_range(TO - 2, TO + 1);
      end else if (r < 70) begin
        rn = 0;
      end
      for (int j = 0; j < n; j++) begin
        drive(rn, bv, d, fe);
        n_checks++;
        if (obs !== model_vec()) begin
          n_fail++;
          $display("FAIL random_it%0d: got %b want %b (byte %h bv %0d fe %0d)", it, obs, model_vec(), d, bv, fe);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_space();
    test_duck();
    test_timeout();
    test_overrun();
    test_frame_err();
    test_back_to_back();
    test_pause();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
